// File: rtl/hx711_scale_ctrl.sv
// HX711 scale sequencer: windowed averaging, tare capture and saturated tare-corrected weight.
// Optional stalled-sensor watchdog enabled by defining HX711_TIMEOUT_EN.
module hx711_scale_ctrl #(
  parameter int AVG_LOG2     = 3,
  parameter int TIMEOUT_CLKS = 20_000_000
) (
  input  logic               clk_100MHz,
  input  logic               rst_n,
  input  logic               ENABLE,
  input  logic signed [23:0] RAW_VAL,
  input  logic               DATA_VALID,
  input  logic               TARE_REQ,
  output logic signed [23:0] WEIGHT,
  output logic               WEIGHT_VALID,
  output logic signed [23:0] TARE_VAL,
  output logic               TARE_DONE,
  output logic               TARE_BUSY,
  output logic               TIMEOUT
);

  localparam int AW = 24 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int N  = 1 << AVG_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TARE    = 2'd2
  } state_t;

  function automatic logic signed [23:0] sat24(input logic signed [24:0] v);
    if (v > 25'sd8388607) begin
      sat24 = 24'sh7FFFFF;
    end else if (v < -25'sd8388608) begin
      sat24 = 24'sh800000;
    end else begin
      sat24 = 24'(v);
    end
  endfunction

  state_t               state_r, state_n;
  logic signed [AW-1:0] acc_r, acc_n;
  logic [CW-1:0]        cnt_r, cnt_n;
  logic                 pend_r, pend_n;
  logic signed [23:0]   weight_r, weight_n;
  logic                 weight_valid_r, weight_valid_n;
  logic signed [23:0]   tare_val_r, tare_val_n;
  logic                 tare_done_r, tare_done_n;

  logic signed [AW-1:0] raw_ext_s;
  logic signed [AW-1:0] sum_s;
  logic signed [23:0]   avg_s;
  logic signed [24:0]   diff_s;
  logic                 take_s;

  assign raw_ext_s = AW'(RAW_VAL);
  assign sum_s     = acc_r + raw_ext_s;
  // Arithmetic shift floors toward minus infinity for negative sums.
  assign avg_s     = 24'(sum_s >>> AVG_LOG2);
  assign diff_s    = 25'(avg_s) - 25'(tare_val_r);

`ifdef HX711_TIMEOUT_EN
  localparam logic [24:0] WD_LIMIT = 25'(TIMEOUT_CLKS);
  logic [24:0] wd_r, wd_n;
  logic [24:0] wd_inc_s;
  logic        timeout_r, timeout_n;
  assign wd_inc_s = wd_r + 25'd1;
`endif

  // Next-state, accumulator, tare and output strobe decisions.
  always_comb begin
    state_n        = state_r;
    acc_n          = acc_r;
    cnt_n          = cnt_r;
    pend_n         = pend_r;
    weight_n       = weight_r;
    weight_valid_n = 1'b0;
    tare_val_n     = tare_val_r;
    tare_done_n    = 1'b0;
    take_s         = 1'b0;

    if (!ENABLE) begin
      state_n = ST_IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      if ((state_r == ST_IDLE) && TARE_REQ) begin
        pend_n = 1'b1;
      end else begin
        pend_n = pend_r;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          acc_n = '0;
          cnt_n = '0;
          if (pend_r || TARE_REQ) begin
            state_n = ST_TARE;
            pend_n  = 1'b0;
          end else begin
            state_n = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // A tare request drops the partial window and any coincident sample.
          if (TARE_REQ || pend_r) begin
            state_n = ST_TARE;
            pend_n  = 1'b0;
            acc_n   = '0;
            cnt_n   = '0;
          end else begin
            take_s = DATA_VALID;
          end
        end
        ST_TARE: begin
          take_s = DATA_VALID;
        end
        default: begin
          state_n = ST_IDLE;
          acc_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end

    if (take_s && (cnt_r == CNT_LAST)) begin
      acc_n = '0;
      cnt_n = '0;
      if (state_r == ST_TARE) begin
        tare_val_n  = avg_s;
        tare_done_n = 1'b1;
        state_n     = ST_MEASURE;
      end else begin
        weight_n       = sat24(diff_s);
        weight_valid_n = 1'b1;
      end
    end else if (take_s) begin
      acc_n = sum_s;
      cnt_n = cnt_r + CW'(1);
    end else begin
      tare_done_n = 1'b0;
    end

`ifdef HX711_TIMEOUT_EN
    wd_n      = wd_r;
    timeout_n = timeout_r;
    if (!ENABLE) begin
      wd_n      = '0;
      timeout_n = 1'b0;
    end else if (state_r == ST_IDLE) begin
      wd_n = '0;
    end else if (DATA_VALID) begin
      wd_n      = '0;
      timeout_n = 1'b0;
    end else if (wd_r != WD_LIMIT) begin
      wd_n = wd_inc_s;
      // Expiry abandons the partial window; the next sample restarts it.
      if (wd_inc_s == WD_LIMIT) begin
        timeout_n = 1'b1;
        acc_n     = '0;
        cnt_n     = '0;
      end else begin
        timeout_n = timeout_r;
      end
    end else begin
      wd_n = wd_r;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      acc_r          <= '0;
      cnt_r          <= '0;
      pend_r         <= 1'b0;
      weight_r       <= 24'sd0;
      weight_valid_r <= 1'b0;
      tare_val_r     <= 24'sd0;
      tare_done_r    <= 1'b0;
    end else begin
      state_r        <= state_n;
      acc_r          <= acc_n;
      cnt_r          <= cnt_n;
      pend_r         <= pend_n;
      weight_r       <= weight_n;
      weight_valid_r <= weight_valid_n;
      tare_val_r     <= tare_val_n;
      tare_done_r    <= tare_done_n;
    end
  end

`ifdef HX711_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      wd_r      <= 25'd0;
      timeout_r <= 1'b0;
    end else begin
      wd_r      <= wd_n;
      timeout_r <= timeout_n;
    end
  end
  assign TIMEOUT = timeout_r;
`else
  assign TIMEOUT = 1'b0;
`endif

  assign WEIGHT       = weight_r;
  assign WEIGHT_VALID = weight_valid_r;
  assign TARE_VAL     = tare_val_r;
  assign TARE_DONE    = tare_done_r;
  assign TARE_BUSY    = (state_r == ST_TARE);

endmodule
